// File: rtl/tcpc_mem_pkg.sv
// Shared types and constants for the TCPC register-file arbiter.
// Requester indices, arbiter state encodings and well-known register addresses.
package tcpc_mem_pkg;

  localparam logic [1:0] REQ_I2C = 2'd0;
  localparam logic [1:0] REQ_TX  = 2'd1;
  localparam logic [1:0] REQ_RX  = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_GNT_I2C = 4'b0010,
    ST_GNT_TX  = 4'b0100,
    ST_GNT_RX  = 4'b1000
  } arb_state_e;

  localparam logic [7:0] ADDR_ALERT_L     = 8'h10;
  localparam logic [7:0] ADDR_ALERT_H     = 8'h11;
  localparam logic [7:0] ADDR_RX_BYTE_CNT = 8'd81;
  localparam logic [7:0] ADDR_HDR_0       = 8'd82;
  localparam logic [7:0] ADDR_HDR_1       = 8'd83;
  localparam logic [7:0] ADDR_FRAME_TYPE  = 8'd49;

  function automatic arb_state_e idx2state(
    input logic [1:0] idx
  );
    arb_state_e s;
    case (idx)
      REQ_I2C: s = ST_GNT_I2C;
      REQ_TX:  s = ST_GNT_TX;
      default: s = ST_GNT_RX;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tcpc_rr_pick3.sv
// Three-way round-robin picker.
// Returns the first requester after 'last' in the order I2C->TX->RX->I2C.
module tcpc_rr_pick3
  import tcpc_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] win
);

  always_comb begin
    win = 3'b000;
    case (last)
      REQ_I2C: begin
        if (req[1])      win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      REQ_TX: begin
        if (req[2])      win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if (req[0])      win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/tcpc_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing the TCPC register file
// between the I2C slave, PRL TX and PRL RX masters.
module tcpc_mem_arbiter
  import tcpc_mem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 6
) (
  input  logic              clk,
  input  logic              hard_reset,
  input  logic              i2c_req,
  input  logic              i2c_rnw,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  input  logic              tx_req,
  input  logic              tx_rnw,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic [DATA_W-1:0] tx_wdata,
  input  logic              rx_req,
  input  logic              rx_rnw,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic [DATA_W-1:0] rx_wdata,
  output logic [2:0]        grant,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        rd_valid,
  output logic              arb_idle
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

  logic [2:0]        req_v;
  logic [2:0]        pick;
  logic [1:0]        pick_idx;

  logic              cur_req;
  logic              cur_rnw;
  logic              others;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              access;

  assign req_v = {rx_req, tx_req, i2c_req};

  tcpc_rr_pick3 u_pick (
    .req  (req_v),
    .last (rr_last_q),
    .win  (pick)
  );

  always_comb begin
    pick_idx = REQ_I2C;
    unique case (1'b1)
      pick[0]: pick_idx = REQ_I2C;
      pick[1]: pick_idx = REQ_TX;
      pick[2]: pick_idx = REQ_RX;
      default: pick_idx = REQ_I2C;
    endcase
  end

  // Master mux driven purely by the registered state.
  always_comb begin
    cur_req   = 1'b0;
    cur_rnw   = 1'b0;
    others    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    case (state_q)
      ST_GNT_I2C: begin
        cur_req   = i2c_req;
        cur_rnw   = i2c_rnw;
        cur_addr  = i2c_addr;
        cur_wdata = i2c_wdata;
        others    = tx_req | rx_req;
      end
      ST_GNT_TX: begin
        cur_req   = tx_req;
        cur_rnw   = tx_rnw;
        cur_addr  = tx_addr;
        cur_wdata = tx_wdata;
        others    = i2c_req | rx_req;
      end
      ST_GNT_RX: begin
        cur_req   = rx_req;
        cur_rnw   = rx_rnw;
        cur_addr  = rx_addr;
        cur_wdata = rx_wdata;
        others    = i2c_req | tx_req;
      end
      default: ;
    endcase
  end

  assign access    = cur_req & ~hard_reset;
  assign mem_en    = access;
  assign mem_we    = access & ~cur_rnw;
  assign mem_addr  = access ? cur_addr : '0;
  assign mem_wdata = access ? cur_wdata : '0;
  assign grant     = state_q[3:1];
  assign arb_idle  = (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_v) begin
          state_d     = idx2state(pick_idx);
          rr_last_d   = pick_idx;
          burst_cnt_d = '0;
        end
      end
      default: begin
        if (!cur_req) begin
          state_d = ST_IDLE;
        end else if (burst_cnt_q == CNT_MAX) begin
          // Counter saturates; release only when someone else waits.
          if (others) state_d = ST_IDLE;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= REQ_RX;
      burst_cnt_q <= '0;
      rdata       <= '0;
      rd_valid    <= 3'b000;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      if (access && cur_rnw) begin
        rdata    <= mem_rdata;
        rd_valid <= state_q[3:1];
      end else begin
        rd_valid <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_tcpc_mem_arbiter.sv
// Directed self-checking bench for tcpc_mem_arbiter.
// Inputs change 1ns after the rising edge, outputs are checked 2ns after it.
module tb_tcpc_mem_arbiter;
  import tcpc_mem_pkg::*;

  logic       clk = 1'b0;
  logic       hard_reset;
  logic       i2c_req, i2c_rnw;
  logic [7:0] i2c_addr, i2c_wdata;
  logic       tx_req, tx_rnw;
  logic [7:0] tx_addr, tx_wdata;
  logic       rx_req, rx_rnw;
  logic [7:0] rx_addr, rx_wdata;
  logic [2:0] grant;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] rdata;
  logic [2:0] rd_valid;
  logic       arb_idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcpc_mem_arbiter #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .MAX_BURST (6)
  ) dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .i2c_req    (i2c_req),
    .i2c_rnw    (i2c_rnw),
    .i2c_addr   (i2c_addr),
    .i2c_wdata  (i2c_wdata),
    .tx_req     (tx_req),
    .tx_rnw     (tx_rnw),
    .tx_addr    (tx_addr),
    .tx_wdata   (tx_wdata),
    .rx_req     (rx_req),
    .rx_rnw     (rx_rnw),
    .rx_addr    (rx_addr),
    .rx_wdata   (rx_wdata),
    .grant      (grant),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rdata      (rdata),
    .rd_valid   (rd_valid),
    .arb_idle   (arb_idle)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hard_reset = 1'b1;
    i2c_req = 0; tx_req = 0; rx_req = 0;
    tick();
    tick();
    hard_reset = 1'b0;
  endtask

  localparam logic [7:0] GCRC [6] = '{ADDR_HDR_1, ADDR_HDR_0,
    ADDR_RX_BYTE_CNT, ADDR_FRAME_TYPE, ADDR_ALERT_L, ADDR_ALERT_H};

  initial begin
    hard_reset = 1'b1;
    i2c_req = 0; i2c_rnw = 0; i2c_addr = 0; i2c_wdata = 0;
    tx_req = 0;  tx_rnw = 0;  tx_addr = 0;  tx_wdata = 0;
    rx_req = 0;  rx_rnw = 0;  rx_addr = 0;  rx_wdata = 0;
    mem_rdata = 8'h00;

    // reset state
    do_reset();
    #1;
    chk("rst_grant", grant, 3'b000);
    chk("rst_idle", arb_idle, 1'b1);
    chk("rst_en", mem_en, 1'b0);
    chk("rst_rdv", rd_valid, 3'b000);
    chk("rst_rdata", rdata, 8'h00);

    // single RX write
    tick();
    rx_req = 1; rx_rnw = 0; rx_addr = 8'd83; rx_wdata = 8'h02;
    #1;
    chk("rx1_c1_en", mem_en, 1'b0);
    tick();
    #1;
    chk("rx1_grant", grant, 3'b100);
    chk("rx1_en", mem_en, 1'b1);
    chk("rx1_we", mem_we, 1'b1);
    chk("rx1_addr", mem_addr, 8'd83);
    chk("rx1_wdata", mem_wdata, 8'h02);
    tick();
    rx_req = 0;
    #1;
    chk("rx1_drop_en", mem_en, 1'b0);
    chk("rx1_drop_addr", mem_addr, 8'h00);
    tick();
    #1;
    chk("rx1_idle", arb_idle, 1'b1);

    // all three requesting from reset
    do_reset();
    i2c_req = 1; i2c_rnw = 0; i2c_addr = 8'd1; i2c_wdata = 8'hA1;
    tx_req = 1;  tx_rnw = 0;  tx_addr = 8'd2;  tx_wdata = 8'hA2;
    rx_req = 1;  rx_rnw = 0;  rx_addr = 8'd3;  rx_wdata = 8'hA3;
    for (int c = 0; c < 23; c++) begin
      int k;
      #1;
      k = (c / 7) % 3;
      if (c % 7 == 0) begin
        chk($sformatf("rr%0d_grant", c), grant, 3'b000);
        chk($sformatf("rr%0d_en", c), mem_en, 1'b0);
      end else begin
        chk($sformatf("rr%0d_grant", c), grant, 3'b001 << k);
        chk($sformatf("rr%0d_en", c), mem_en, 1'b1);
        chk($sformatf("rr%0d_addr", c), mem_addr, k + 1);
      end
      tick();
    end
    i2c_req = 0; tx_req = 0; rx_req = 0;

    // I2C read
    do_reset();
    i2c_req = 1; i2c_rnw = 1; i2c_addr = ADDR_ALERT_L;
    mem_rdata = 8'h04;
    tick();
    #1;
    chk("rd_en", mem_en, 1'b1);
    chk("rd_we", mem_we, 1'b0);
    chk("rd_addr", mem_addr, 8'h10);
    chk("rd_rdv0", rd_valid, 3'b000);
    tick();
    i2c_req = 0;
    mem_rdata = 8'hEE;
    #1;
    chk("rd_rdv1", rd_valid, 3'b001);
    chk("rd_rdata", rdata, 8'h04);
    chk("rd_en_off", mem_en, 1'b0);
    tick();
    #1;
    chk("rd_rdv2", rd_valid, 3'b000);
    chk("rd_hold", rdata, 8'h04);
    chk("rd_idle", arb_idle, 1'b1);

    // RX GoodCRC burst of six writes
    do_reset();
    rx_req = 1; rx_rnw = 0; rx_addr = GCRC[0]; rx_wdata = 8'h00;
    tick();
    for (int i = 0; i < 6; i++) begin
      rx_addr = GCRC[i];
      rx_wdata = 8'(i + 8'h30);
      #1;
      chk($sformatf("gc%0d_grant", i), grant, 3'b100);
      chk($sformatf("gc%0d_en", i), mem_en, 1'b1);
      chk($sformatf("gc%0d_addr", i), mem_addr, GCRC[i]);
      chk($sformatf("gc%0d_wd", i), mem_wdata, i + 8'h30);
      tick();
    end
    rx_req = 0;
    #1;
    chk("gc_end_en", mem_en, 1'b0);
    tick();
    #1;
    chk("gc_idle", arb_idle, 1'b1);

    // saturated burst then forced release to a late waiter
    do_reset();
    rx_req = 1; rx_addr = 8'h40;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        i2c_req = 1; i2c_rnw = 0; i2c_addr = 8'h55;
      end
      #1;
      chk($sformatf("sat%0d_grant", i), grant, 3'b100);
      chk($sformatf("sat%0d_en", i), mem_en, 1'b1);
      tick();
    end
    #1;
    chk("sat_bubble", arb_idle, 1'b1);
    chk("sat_bub_en", mem_en, 1'b0);
    tick();
    #1;
    chk("sat_next", grant, 3'b001);
    chk("sat_next_addr", mem_addr, 8'h55);
    i2c_req = 0; rx_req = 0;

    // TX drops mid-burst with I2C waiting
    do_reset();
    tx_req = 1; tx_rnw = 0; tx_addr = 8'h20;
    tick();
    i2c_req = 1; i2c_rnw = 0; i2c_addr = 8'h66;
    #1;
    chk("txd_g1", grant, 3'b010);
    chk("txd_en1", mem_en, 1'b1);
    tick();
    #1;
    chk("txd_g2", grant, 3'b010);
    tick();
    tx_req = 0;
    #1;
    chk("txd_drop_g", grant, 3'b010);
    chk("txd_drop_en", mem_en, 1'b0);
    tick();
    #1;
    chk("txd_idle", arb_idle, 1'b1);
    chk("txd_idle_g", grant, 3'b000);
    tick();
    #1;
    chk("txd_i2c_g", grant, 3'b001);
    chk("txd_i2c_addr", mem_addr, 8'h66);
    i2c_req = 0;

    // hard_reset in the middle of a TX read burst
    do_reset();
    tx_req = 1; tx_rnw = 1; tx_addr = 8'h21;
    mem_rdata = 8'h5A;
    tick();
    #1;
    chk("hr_g1", grant, 3'b010);
    tick();
    hard_reset = 1;
    #1;
    chk("hr_rdv", rd_valid, 3'b010);
    chk("hr_rdata", rdata, 8'h5A);
    tick();
    hard_reset = 0;
    i2c_req = 1; i2c_rnw = 0; i2c_addr = 8'h77;
    #1;
    chk("hr_grant", grant, 3'b000);
    chk("hr_en", mem_en, 1'b0);
    chk("hr_idle", arb_idle, 1'b1);
    chk("hr_rdv0", rd_valid, 3'b000);
    chk("hr_rdata0", rdata, 8'h00);
    tick();
    #1;
    chk("hr_rr_i2c", grant, 3'b001);
    i2c_req = 0; tx_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
